// File: rtl/add_sequencer_pkg.sv
// rtl/add_sequencer_pkg.sv - shared state encodings and slice width for add_sequencer
// Contents: state_e (ST_IDLE, ST_RUN, ST_DONE, ST_ILLEGAL) and SLICE_W.
package add_sequencer_pkg;

  localparam int SLICE_W = 8;

  // ST_ILLEGAL is unreachable in normal operation and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

endpackage

// File: rtl/eight_bit_look_ahead_adder.sv
// rtl/eight_bit_look_ahead_adder.sv - 8-bit carry look-ahead adder slice
// Ports: a, b (SLICE_W) addends; cin carry in; sum (SLICE_W); cout carry out of bit 7.
module eight_bit_look_ahead_adder
  import add_sequencer_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;
  logic               prod;

  // Each carry is the flat sum of products
  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, with no ripple chain.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    prod = 1'b0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      c[i+1] = g[i];
      prod   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prod & g[j]);
        prod   = prod & p[j];
      end
      c[i+1] = c[i+1] | (prod & cin);
    end
  end

  assign sum  = p ^ c[SLICE_W-1:0];
  assign cout = c[SLICE_W];

endmodule

// File: rtl/add_sequencer.sv
// rtl/add_sequencer.sv - multi-cycle add/subtract over a shared 8-bit look-ahead slice
// Ports: clock, reset_n (async, active-low); start, op_sub, a, b request;
//        abort cancel; ready/busy/done status; result, cout, overflow registered.
module add_sequencer
  import add_sequencer_pkg::*;
#(
  parameter  int WIDTH  = 32,
  localparam int NSLICE = WIDTH / SLICE_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e             state_q,    state_d;
  logic [WIDTH-1:0]   opa_q,      opa_d;
  logic [WIDTH-1:0]   opb_q,      opb_d;
  logic               carry_q,    carry_d;
  logic [IDX_W-1:0]   idx_q,      idx_d;
  logic [WIDTH-1:0]   result_q,   result_d;
  logic               cout_q,     cout_d;
  logic               overflow_q, overflow_d;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  // Byte select for the shared slice.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int s = 0; s < NSLICE; s++) begin
      if (idx_q == IDX_W'(s)) begin
        slice_a = opa_q[s*SLICE_W +: SLICE_W];
        slice_b = opb_q[s*SLICE_W +: SLICE_W];
      end
    end
  end

  eight_bit_look_ahead_adder u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Subtract is a + ~b + 1: invert b here, the +1 enters as carry-in.
          opa_d      = a;
          opb_d      = op_sub ? ~b : b;
          carry_d    = op_sub;
          idx_d      = '0;
          result_d   = '0;
          cout_d     = 1'b0;
          overflow_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          result_d   = '0;
          cout_d     = 1'b0;
          overflow_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          for (int s = 0; s < NSLICE; s++) begin
            if (idx_q == IDX_W'(s)) begin
              result_d[s*SLICE_W +: SLICE_W] = slice_sum;
            end
          end
          carry_d = slice_cout;
          if (idx_q == LAST_IDX) begin
            // Overflow uses the inverted b, so add and subtract share one rule.
            cout_d     = slice_cout;
            overflow_d = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                         (slice_sum[SLICE_W-1] != opa_q[WIDTH-1]);
            state_d    = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_add_sequencer.sv
// tb/tb_add_sequencer.sv - randomized and directed bench for add_sequencer
module tb_add_sequencer;

  localparam int WIDTH  = 32;
  localparam int NSLICE = 4;

  logic              clock   = 1'b0;
  logic              reset_n = 1'b0;
  logic              start   = 1'b0;
  logic              op_sub  = 1'b0;
  logic              abort   = 1'b0;
  logic [WIDTH-1:0]  a       = '0;
  logic [WIDTH-1:0]  b       = '0;
  logic              ready, busy, done, cout, overflow;
  logic [WIDTH-1:0]  result;

  int compared   = 0;
  int mismatched = 0;

  add_sequencer #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .abort    (abort),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  // Reference model: m_cnt counts cycles since acceptance
  // (0 idle, 1..NSLICE running, NSLICE+1 done).
  int          m_cnt  = 0;
  logic [31:0] m_res  = '0;
  logic        m_co   = 1'b0;
  logic        m_ov   = 1'b0;
  logic [31:0] m_pres = '0;
  logic        m_pco  = 1'b0;
  logic        m_pov  = 1'b0;

  task automatic model_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    longint sa, sb, r;
    logic [32:0] wide;
    sa = longint'($signed(ta));
    sb = longint'($signed(tb));
    if (ts) begin
      r      = sa - sb;
      m_pres = ta - tb;
      m_pco  = (ta >= tb);
    end else begin
      r      = sa + sb;
      wide   = {1'b0, ta} + {1'b0, tb};
      m_pres = wide[31:0];
      m_pco  = wide[32];
    end
    m_pov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt = 0; m_res = '0; m_co = 1'b0; m_ov = 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        model_op(a, b, op_sub);
        m_res = '0; m_co = 1'b0; m_ov = 1'b0;
        m_cnt = 1;
      end
    end else if (m_cnt <= NSLICE) begin
      if (abort) begin
        m_cnt = 0; m_res = '0; m_co = 1'b0; m_ov = 1'b0;
      end else if (m_cnt == NSLICE) begin
        m_cnt = NSLICE + 1;
        m_res = m_pres; m_co = m_pco; m_ov = m_pov;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      m_cnt = 0;
    end
  end

  always @(negedge clock) begin
    compared++;
    if ({ready, busy, done} !== {m_cnt == 0, (m_cnt >= 1) && (m_cnt <= NSLICE), m_cnt == NSLICE + 1}) begin
      mismatched++;
      $display("FAIL handshake @%0t: got ready/busy/done=%b%b%b want %b%b%b", $time,
               ready, busy, done, m_cnt == 0, (m_cnt >= 1) && (m_cnt <= NSLICE), m_cnt == NSLICE + 1);
    end
    if (m_cnt == 0 || m_cnt == NSLICE + 1) begin
      compared++;
      if ({result, cout, overflow} !== {m_res, m_co, m_ov}) begin
        mismatched++;
        $display("FAIL outputs @%0t: got result=%h cout=%b ovf=%b want result=%h cout=%b ovf=%b",
                 $time, result, cout, overflow, m_res, m_co, m_ov);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    @(posedge clock); #1;
    while (!ready && k < 20) begin
      @(posedge clock); #1;
      k++;
    end
    check("wait for ready", {31'd0, ready}, 32'd1);
  endtask

  // Returns edges counted from the accepting edge (inclusive) to the edge that raised done.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts, output int n);
    wait_ready();
    start = 1'b1; a = ta; b = tb; op_sub = ts;
    @(posedge clock); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 12) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic op_check(input string name, input logic [31:0] ta, input logic [31:0] tb,
                          input logic ts, input logic [31:0] er, input logic eco, input logic eov);
    int n;
    do_op(ta, tb, ts, n);
    check({name, " latency"}, n, NSLICE + 1);
    check({name, " done"}, {31'd0, done}, 32'd1);
    check({name, " result"}, result, er);
    check({name, " cout"}, {31'd0, cout}, {31'd0, eco});
    check({name, " overflow"}, {31'd0, overflow}, {31'd0, eov});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int last, pulses;

    #7;
    check("reset ready", {31'd0, ready}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset result", result, 32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Reset in the middle of RUN
    wait_ready();
    start = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; op_sub = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("midrun reset ready", {31'd0, ready}, 32'd1);
    check("midrun reset busy", {31'd0, busy}, 32'd0);
    check("midrun reset done", {31'd0, done}, 32'd0);
    check("midrun reset result", result, 32'h0);
    check("midrun reset cout/ovf", {30'd0, cout, overflow}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    op_check("3+4", 32'd3, 32'd4, 1'b0, 32'h0000_0007, 1'b0, 1'b0);

    op_check("FF+1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    op_check("5-7", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    op_check("7-5", 32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    op_check("max+1", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    op_check("all1+1", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    op_check("min+min", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    op_check("min-1", 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // start held high with operands changing every cycle
    wait_ready();
    start = 1'b1;
    last = -1;
    pulses = 0;
    for (int c = 0; c < 26; c++) begin
      a = $urandom; b = $urandom; op_sub = 1'($urandom % 2);
      @(posedge clock); #1;
      if (done) begin
        if (last >= 0) check("held-start done spacing", c - last, NSLICE + 2);
        last = c;
        pulses++;
      end
    end
    start = 1'b0;
    check("held-start done pulses", pulses, 4);

    // abort in the 2nd RUN cycle
    wait_ready();
    start = 1'b1; a = 32'h0102_0304; b = 32'h1111_1111; op_sub = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort early ready", {31'd0, ready}, 32'd1);
    check("abort early done", {31'd0, done}, 32'd0);
    check("abort early result", result, 32'h0);

    // abort on the final RUN cycle
    start = 1'b1; a = 32'h8000_00FF; b = 32'h8000_0001; op_sub = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort final ready", {31'd0, ready}, 32'd1);
    check("abort final done", {31'd0, done}, 32'd0);
    check("abort final result", result, 32'h0);
    check("abort final cout/ovf", {30'd0, cout, overflow}, 32'd0);
    op_check("after abort", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

    // Randomized traffic: starts while busy, aborts at random points, one async reset
    for (int i = 0; i < 400; i++) begin
      @(posedge clock); #1;
      start  = ($urandom % 3) == 0;
      op_sub = 1'($urandom % 2);
      a      = pick();
      b      = pick();
      abort  = ($urandom % 12) == 0;
      if (i == 200) begin
        #2 reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (8) @(posedge clock);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
